// File: rtl/data_width_converter.sv
// data_width_converter
//   Streams IN_WIDTH-bit beats out as OUT_WIDTH-bit words. The mode is fixed
//   by the parameters:
//     pack     (OUT > IN)  : RATIO beats are gathered into one word, LSB first.
//     unpack   (OUT < IN)  : one beat is split into RATIO slices, LSB first.
//     register (OUT == IN) : one-stage pipeline register.
//   Both sides use a req/ready handshake, and a burst marker travels with the
//   data. s_write_last closes a partial word in pack mode.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous reset, active low
//   s_write_req     input beat valid
//   s_write_ready   converter accepts a beat this cycle
//   s_write_data    input beat
//   s_write_last    beat ends a burst (flushes a partial word)
//   m_write_req     output word valid
//   m_write_ready   downstream accepts the word
//   m_write_data    output word
//   m_write_last    word ends a burst
//   m_write_num_ops number of valid OP_WIDTH lanes, counted from the LSB
module data_width_converter #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 128,
    parameter int OP_WIDTH  = 16,
    localparam int NUM_OPS_W = $clog2(OUT_WIDTH / OP_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_write_req,
    output logic                 s_write_ready,
    input  logic [IN_WIDTH-1:0]  s_write_data,
    input  logic                 s_write_last,
    output logic                 m_write_req,
    input  logic                 m_write_ready,
    output logic [OUT_WIDTH-1:0] m_write_data,
    output logic                 m_write_last,
    output logic [NUM_OPS_W-1:0] m_write_num_ops
);

    localparam int MAX_W   = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int MIN_W   = (IN_WIDTH > OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;
    localparam int RATIO   = MAX_W / MIN_W;
    localparam int CNT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int OUT_OPS = OUT_WIDTH / OP_WIDTH;

    if (IN_WIDTH % OP_WIDTH != 0) begin : g_bad_in_width
        $error("IN_WIDTH must be a multiple of OP_WIDTH");
    end
    if (OUT_WIDTH % OP_WIDTH != 0) begin : g_bad_out_width
        $error("OUT_WIDTH must be a multiple of OP_WIDTH");
    end
    if (MAX_W % MIN_W != 0) begin : g_bad_ratio
        $error("larger width must be an integer multiple of the smaller width");
    end

    // en_q keeps s_write_ready low during reset and raises it one edge
    // after reset is released.
    logic             en_q, en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             last_q, last_d;
    logic             s_fire;
    logic             m_fire;

    assign en_d        = 1'b1;
    assign s_fire      = s_write_req && s_write_ready;
    assign m_fire      = m_write_req && m_write_ready;
    assign m_write_req = req_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            en_q   <= 1'b0;
            cnt_q  <= '0;
            req_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            last_q <= last_d;
        end
    end

    if (OUT_WIDTH >= IN_WIDTH) begin : g_pack
        // Register mode is the pack path with RATIO == 1. Every beat closes
        // a word in that case.
        logic [OUT_WIDTH-1:0] acc_q, acc_d;
        logic [OUT_WIDTH-1:0] data_q, data_d;
        logic [NUM_OPS_W-1:0] nops_q, nops_d;
        logic [OUT_WIDTH-1:0] word_nxt;
        logic [NUM_OPS_W-1:0] nops_nxt;
        logic                 close_word;

        // A new word can be accepted whenever the output slot is free or
        // is being drained in the same cycle.
        assign s_write_ready   = en_q && !(req_q && !m_write_ready);
        assign m_write_data    = data_q;
        assign m_write_last    = last_q;
        assign m_write_num_ops = nops_q;

        always_comb begin
            acc_d      = acc_q;
            data_d     = data_q;
            nops_d     = nops_q;
            cnt_d      = cnt_q;
            req_d      = req_q;
            last_d     = last_q;
            word_nxt   = acc_q;
            nops_nxt   = '0;
            close_word = (cnt_q == CNT_W'(RATIO - 1)) || s_write_last;

            for (int s = 0; s < RATIO; s++) begin
                if (cnt_q == CNT_W'(s)) begin
                    word_nxt[s*IN_WIDTH +: IN_WIDTH] = s_write_data;
                    nops_nxt = NUM_OPS_W'((s + 1) * (IN_WIDTH / OP_WIDTH));
                end
            end

            if (m_fire) begin
                req_d = 1'b0;
            end

            if (s_fire) begin
                if (close_word) begin
                    // The accumulator is cleared on every close, so the slots
                    // above the closing beat are already zero.
                    data_d = word_nxt;
                    nops_d = nops_nxt;
                    last_d = s_write_last;
                    req_d  = 1'b1;
                    acc_d  = '0;
                    cnt_d  = '0;
                end else begin
                    acc_d = word_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                acc_q  <= '0;
                data_q <= '0;
                nops_q <= '0;
            end else begin
                acc_q  <= acc_d;
                data_q <= data_d;
                nops_q <= nops_d;
            end
        end
    end else begin : g_unpack
        // The holding register shifts right by one slice per output transfer,
        // so the slice on the bus is always in the low bits.
        logic [IN_WIDTH-1:0] hold_q, hold_d;
        logic                final_slice;

        assign final_slice     = (cnt_q == CNT_W'(RATIO - 1));
        assign s_write_ready   = en_q && (!req_q || (final_slice && m_write_ready));
        assign m_write_data    = hold_q[OUT_WIDTH-1:0];
        assign m_write_last    = req_q && last_q && final_slice;
        assign m_write_num_ops = req_q ? NUM_OPS_W'(OUT_OPS) : '0;

        always_comb begin
            hold_d = hold_q;
            cnt_d  = cnt_q;
            req_d  = req_q;
            last_d = last_q;

            if (m_fire) begin
                if (final_slice) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    hold_d = hold_q >> OUT_WIDTH;
                end
            end

            // A new beat can only land while the final slice leaves, so it
            // overrides the drain update above.
            if (s_fire) begin
                hold_d = s_write_data;
                cnt_d  = '0;
                req_d  = 1'b1;
                last_d = s_write_last;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_d;
            end
        end
    end

endmodule

// File: tb/tb_data_width_converter.sv
module tb_data_width_converter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // instance A: pack 64 -> 128
    logic         a_s_req, a_s_ready, a_s_last, a_m_req, a_m_ready, a_m_last;
    logic [63:0]  a_s_data;
    logic [127:0] a_m_data;
    logic [3:0]   a_m_nops;

    // instance B: unpack 128 -> 32
    logic         b_s_req, b_s_ready, b_s_last, b_m_req, b_m_ready, b_m_last;
    logic [127:0] b_s_data;
    logic [31:0]  b_m_data;
    logic [1:0]   b_m_nops;

    data_width_converter #(.IN_WIDTH(64), .OUT_WIDTH(128), .OP_WIDTH(16)) u_pack (
        .clk(clk), .reset(reset),
        .s_write_req(a_s_req), .s_write_ready(a_s_ready), .s_write_data(a_s_data),
        .s_write_last(a_s_last),
        .m_write_req(a_m_req), .m_write_ready(a_m_ready), .m_write_data(a_m_data),
        .m_write_last(a_m_last), .m_write_num_ops(a_m_nops)
    );

    data_width_converter #(.IN_WIDTH(128), .OUT_WIDTH(32), .OP_WIDTH(16)) u_unpack (
        .clk(clk), .reset(reset),
        .s_write_req(b_s_req), .s_write_ready(b_s_ready), .s_write_data(b_s_data),
        .s_write_last(b_s_last),
        .m_write_req(b_m_req), .m_write_ready(b_m_ready), .m_write_data(b_m_data),
        .m_write_last(b_m_last), .m_write_num_ops(b_m_nops)
    );

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [3:0]   nops;
    } word_t;

    word_t       exp_a[$];
    word_t       exp_b[$];
    logic [63:0] pend_a[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          live    = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pack reference: collect beats and emit a word once 2 beats are
    // collected or the last marker arrives.
    task automatic model_a(input logic [63:0] d, input logic l);
        word_t e;
        pend_a.push_back(d);
        if (pend_a.size() == 2 || l) begin
            e.data = '0;
            foreach (pend_a[i]) e.data[i*64 +: 64] = pend_a[i];
            e.last = l;
            e.nops = 4'(pend_a.size() * 4);
            exp_a.push_back(e);
            pend_a.delete();
        end
    endtask

    // Unpack reference: a beat becomes four 32-bit slices, LSB first.
    task automatic model_b(input logic [127:0] d, input logic l);
        word_t e;
        for (int j = 0; j < 4; j++) begin
            e.data = {96'h0, d[j*32 +: 32]};
            e.last = l && (j == 3);
            e.nops = 4'd2;
            exp_b.push_back(e);
        end
    endtask

    // One clock cycle: sample at the falling edge, check against the
    // model, update the model from the handshakes, then return 1 time unit
    // after the rising edge.
    task automatic step();
        @(negedge clk);
        if (!reset) begin
            live = 1'b0;
            pend_a.delete();
            exp_a.delete();
            exp_b.delete();
        end else begin
            chk("a_req", a_m_req, exp_a.size() != 0);
            if (a_m_req && exp_a.size() != 0) begin
                chk("a_data", a_m_data, exp_a[0].data);
                chk("a_last", a_m_last, exp_a[0].last);
                chk("a_nops", a_m_nops, exp_a[0].nops);
            end
            chk("b_req", b_m_req, exp_b.size() != 0);
            if (b_m_req && exp_b.size() != 0) begin
                chk("b_data", b_m_data, exp_b[0].data);
                chk("b_last", b_m_last, exp_b[0].last);
                chk("b_nops", b_m_nops, exp_b[0].nops);
            end
            if (live) begin
                chk("a_ready", a_s_ready, !(exp_a.size() != 0 && !a_m_ready));
                chk("b_ready", b_s_ready, exp_b.size() == 0 || (exp_b.size() == 1 && b_m_ready));
            end
            if (a_m_req && a_m_ready && exp_a.size() != 0) void'(exp_a.pop_front());
            if (b_m_req && b_m_ready && exp_b.size() != 0) void'(exp_b.pop_front());
            if (a_s_req && a_s_ready) model_a(a_s_data, a_s_last);
            if (b_s_req && b_s_ready) model_b(b_s_data, b_s_last);
            live = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] ub;
        reset     = 1'b0;
        a_s_req   = 1'b0; a_s_last = 1'b0; a_s_data = '0; a_m_ready = 1'b1;
        b_s_req   = 1'b0; b_s_last = 1'b0; b_s_data = '0; b_m_ready = 1'b1;

        // reset state
        step(); step();
        chk("rst_a_req", a_m_req, 1'b0);
        chk("rst_a_data", a_m_data, 128'h0);
        chk("rst_a_ready", a_s_ready, 1'b0);
        chk("rst_a_nops", a_m_nops, 4'h0);
        chk("rst_b_req", b_m_req, 1'b0);
        chk("rst_b_ready", b_s_ready, 1'b0);
        chk("rst_b_data", b_m_data, 32'h0);
        reset = 1'b1;
        step();
        chk("rel_a_ready", a_s_ready, 1'b1);
        chk("rel_b_ready", b_s_ready, 1'b1);

        // pack at full rate
        a_s_req = 1'b1;
        a_s_data = 64'h1111_1111_1111_1111; step();
        a_s_data = 64'h2222_2222_2222_2222; step();
        chk("pk_w0_req", a_m_req, 1'b1);
        chk("pk_w0_data", a_m_data, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        chk("pk_w0_nops", a_m_nops, 4'd8);
        chk("pk_w0_last", a_m_last, 1'b0);
        a_s_data = 64'h3333_3333_3333_3333; step();
        a_s_data = 64'h4444_4444_4444_4444; step();
        chk("pk_w1_data", a_m_data, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333});

        // flush on beat 0
        a_s_data = 64'hAAAA_BBBB_CCCC_DDDD; a_s_last = 1'b1; step();
        chk("fl_data", a_m_data, {64'h0, 64'hAAAA_BBBB_CCCC_DDDD});
        chk("fl_nops", a_m_nops, 4'd4);
        chk("fl_last", a_m_last, 1'b1);
        a_s_last = 1'b0;
        a_s_data = 64'h5555_5555_5555_5555; step();
        a_s_data = 64'h6666_6666_6666_6666; step();
        chk("fl_next_data", a_m_data, {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
        chk("fl_next_last", a_m_last, 1'b0);
        a_s_req = 1'b0; step();

        // backpressure on a completed word
        a_m_ready = 1'b0; a_s_req = 1'b1;
        a_s_data = 64'h7777_7777_7777_7777; step();
        a_s_data = 64'h8888_8888_8888_8888; step();
        a_s_data = 64'h9999_9999_9999_9999;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", a_s_ready, 1'b0);
            chk("bp_req_high", a_m_req, 1'b1);
            chk("bp_data_hold", a_m_data, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777});
            step();
        end
        a_m_ready = 1'b1; step();
        a_s_data = 64'hCAFE_CAFE_CAFE_CAFE; step();
        chk("bp_resume_data", a_m_data, {64'hCAFE_CAFE_CAFE_CAFE, 64'h9999_9999_9999_9999});
        a_s_req = 1'b0; step();

        // reset after one of two beats
        a_s_req = 1'b1; a_s_data = 64'hD1D1_D1D1_D1D1_D1D1; step();
        a_s_req = 1'b0; reset = 1'b0; step();
        chk("mr_a_req", a_m_req, 1'b0);
        chk("mr_a_data", a_m_data, 128'h0);
        chk("mr_a_last", a_m_last, 1'b0);
        chk("mr_a_nops", a_m_nops, 4'h0);
        chk("mr_a_ready", a_s_ready, 1'b0);
        reset = 1'b1; step();
        chk("mr_ready_back", a_s_ready, 1'b1);
        a_s_req = 1'b1;
        a_s_data = 64'hE1E1_E1E1_E1E1_E1E1; step();
        a_s_data = 64'hE2E2_E2E2_E2E2_E2E2; step();
        chk("mr_new_word", a_m_data, {64'hE2E2_E2E2_E2E2_E2E2, 64'hE1E1_E1E1_E1E1_E1E1});
        a_s_req = 1'b0; step();

        // unpack a single beat with last
        ub = 128'h44444444_33333333_22222222_11111111;
        b_s_req = 1'b1; b_s_last = 1'b1; b_s_data = ub; step();
        b_s_req = 1'b0; b_s_last = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("up_req", b_m_req, 1'b1);
            chk("up_slice", b_m_data, ub[j*32 +: 32]);
            chk("up_last", b_m_last, j == 3);
            if (j < 3) chk("up_ready_low", b_s_ready, 1'b0);
            step();
        end
        chk("up_idle", b_m_req, 1'b0);

        // unpack back-to-back at full rate
        b_s_req = 1'b1;
        b_s_data = {$urandom, $urandom, $urandom, $urandom}; step();
        for (int i = 0; i < 20; i++) begin
            chk("b2b_no_bubble", b_m_req, 1'b1);
            b_s_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        b_s_req = 1'b0;

        // randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            a_s_req   = ($urandom % 4) != 0;
            a_s_last  = ($urandom % 8) == 0;
            a_s_data  = {$urandom, $urandom};
            a_m_ready = ($urandom % 3) != 0;
            b_s_req   = ($urandom % 3) == 0;
            b_s_last  = ($urandom % 4) == 0;
            b_s_data  = {$urandom, $urandom, $urandom, $urandom};
            b_m_ready = ($urandom % 3) != 0;
            step();
        end

        // flush any partial pack word, then drain both sides
        b_s_req = 1'b0; a_m_ready = 1'b1; b_m_ready = 1'b1;
        while (!a_s_ready) step();
        a_s_req = 1'b1; a_s_last = 1'b1; a_s_data = {$urandom, $urandom}; step();
        a_s_req = 1'b0; a_s_last = 1'b0;
        for (int k = 0; k < 60 && (exp_a.size() != 0 || exp_b.size() != 0); k++) step();
        chk("drain_a_empty", 128'(exp_a.size()), 128'h0);
        chk("drain_b_empty", 128'(exp_b.size()), 128'h0);
        chk("drain_pend_empty", 128'(pend_a.size()), 128'h0);
        chk("drain_a_req", a_m_req, 1'b0);
        chk("drain_b_req", b_m_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_width_converter.md
Name: data_width_converter

Overview:
- Parametrised successor to the team's fixed-ratio packer.
- Converts a stream between IN_WIDTH and OUT_WIDTH in either direction: pack (OUT > IN), unpack (OUT < IN) or register (OUT == IN).
- Uses full req/ready backpressure on both sides, supports a flush/last marker and reports valid operand lanes per output word.
- Sits between DMA read/write buffers and PE-array operand buses in the dnnweaver datapath.

Parameters:
IN_WIDTH, 64, input beat width; multiple of OP_WIDTH.
OUT_WIDTH, 128, output word width; multiple of OP_WIDTH; the larger of IN/OUT is an integer multiple of the smaller.
OP_WIDTH, 16, operand (lane) width used for m_write_num_ops.
(derived) RATIO = max(IN,OUT)/min(IN,OUT); NUM_OPS_W = C_LOG_2(OUT_WIDTH/OP_WIDTH)+1.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
s_write_req  input  1  input beat valid.
s_write_ready  output  1  converter accepts a beat this cycle.
s_write_data  input  IN_WIDTH  input beat.
s_write_last  input  1  beat is the last of a burst; forces flush.
m_write_req  output  1  output word valid.
m_write_ready  input  1  downstream accepts the word.
m_write_data  output  OUT_WIDTH  output word.
m_write_last  output  1  word ends a burst.
m_write_num_ops  output  NUM_OPS_W  count of valid OP_WIDTH lanes in m_write_data, starting from the LSB.

Behaviour:
- Handshakes
  - An input transfer occurs when s_write_req && s_write_ready; an output transfer occurs when m_write_req && m_write_ready.
  - While m_write_req=1 and m_write_ready=0, m_write_data, m_write_last and m_write_num_ops hold stable, and m_write_req stays 1.
- Reset
  - Applied when reset==0 at a clock edge.
  - All outputs go to 0, including s_write_ready. Beat counter, accumulator and holding registers clear.
  - Any partial word is discarded. s_write_ready rises on the first edge after release.
- Pack mode (OUT > IN)
  - Beat k (k=0..RATIO-1) of a word is written to bits [k*IN_WIDTH +: IN_WIDTH], so the first beat lands in the LSBs.
  - s_write_ready = !(m_write_req && !m_write_ready).
  - When the beat with k==RATIO-1 is accepted, or any beat with s_write_last=1:
    - the next cycle, m_write_req=1 with the assembled word;
    - unfilled upper slots are 0;
    - m_write_num_ops = (k+1)*IN_WIDTH/OP_WIDTH;
    - m_write_last = s_write_last of the closing beat.
  - The beat counter then wraps to 0.
  - Latency is 1 cycle from the closing beat. Throughput is one word per RATIO beats with no bubbles while m_write_ready=1.
- Unpack mode (OUT < IN)
  - An accepted beat is stored in a holding register. Slices j=0..RATIO-1 are emitted from bits [j*OUT_WIDTH +: OUT_WIDTH], LSB first, one per output transfer.
  - The first slice is presented the cycle after acceptance.
  - s_write_ready = holding empty, or (slice j==RATIO-1 is presented and m_write_ready=1). This allows back-to-back beats with no bubble.
  - m_write_num_ops = OUT_WIDTH/OP_WIDTH on every slice.
  - m_write_last = 1 only on the final slice of a beat accepted with s_write_last=1.
- Register mode (OUT == IN)
  - One-stage pipeline register, latency 1. Same ready rule as pack mode.
  - num_ops = OUT_WIDTH/OP_WIDTH; last is passed through.
- Boundary conditions
  - If an output transfer and an input transfer occur in the same cycle, both take effect; the new word or slice replaces the old one with no dropped or duplicated data.
  - s_write_last on beat 0 in pack mode emits a word with only slot 0 filled.
  - s_write_req with s_write_ready=0 has no effect.
  - Counter wrap-around is exact modulo RATIO.
- Illegal parameter combinations (non-integer ratio, widths not multiples of OP_WIDTH) fail elaboration.

Test Plan:
- Pack, defaults (64->128), m_write_ready=1
  - Stimulus: beats 0x1111..., 0x2222..., 0x3333..., 0x4444...
  - Response: word0 = {0x2222...,0x1111...} one cycle after beat 2, word1 = {0x4444...,0x3333...}; num_ops=8; last=0.
- Pack flush
  - Stimulus: a single beat 0xAAAA_BBBB_CCCC_DDDD with s_write_last=1.
  - Response: m_write_data = {64'h0, 64'hAAAA_BBBB_CCCC_DDDD}, num_ops=4, last=1. The next beat starts at slot 0.
- Unpack, IN=128 OUT=32
  - Stimulus: one beat 0x44444444_33333333_22222222_11111111 with last=1.
  - Response: slices 0x11111111, 0x22222222, 0x33333333, 0x44444444; last=1 only on 0x44444444; s_write_ready=0 during slices 0-2.
- Backpressure
  - Stimulus: in pack mode, hold m_write_ready=0 for 5 cycles after a word completes.
  - Response: word is stable; s_write_ready=0 for those 5 cycles; no beats are lost; streaming resumes on release.
- Reset mid-word
  - Stimulus: drive reset=0 after 1 of 2 beats.
  - Response: all outputs are 0 in the following cycle. After release, 2 new beats produce one word containing only the new data.
- Back-to-back unpack at full rate
  - Stimulus: unpack mode, s_write_req held 1, m_write_ready=1.
  - Response: m_write_req stays continuously 1 with no bubbles between beats.
